dpb_port_arbiter: RTL and testbench
===================================

// Module: dpb_port_arbiter
// PURPOSE
//  Shares port A of the 512x8 Gowin DPB buffer between two requesters:
//  R0 = Z80 bus-side logic, R1 = ESP/SPI-side logic. Port B is not touched.
//  Runs one RAM access at a time through a 4-state sequencer.
//  Returns per-requester ack and read data with fixed latency.
// PARAMETERS
//  ADDR_W   9  RAM address width (512 entries)
//  DATA_W   8  RAM data width
//  R0_PRIO  0  1 = R0 has strict priority; 0 = round-robin between R0 and R1
// PORTS
//  clk        in   1       system clock; everything on the rising edge
//  rst_n      in   1       asynchronous, active-low reset
//  r0_req     in   1       R0 access request; hold high until r0_ack
//  r0_we      in   1       R0 1=write, 0=read; stable while r0_req is high
//  r0_addr    in   ADDR_W  R0 address; stable while r0_req is high
//  r0_wdata   in   DATA_W  R0 write data; stable while r0_req is high
//  r0_ack     out  1       one-cycle completion pulse for R0
//  r0_rdata   out  DATA_W  R0 read data; valid from the r0_ack cycle, held until next R0 read ack
//  r1_*       same set as r0_* for requester R1
//  busy       out  1       high while state != IDLE
//  ram_ce     out  1       to DPB cea
//  ram_oce    out  1       to DPB ocea; constant 1 (bypass read mode)
//  ram_reset  out  1       to DPB reseta; constant 0
//  ram_we     out  1       to DPB wrea
//  ram_ad     out  ADDR_W  to DPB ada
//  ram_din    out  DATA_W  to DPB dina
//  ram_dout   in   DATA_W  from DPB douta; valid 1 cycle after the ce edge
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - state=IDLE; all acks, busy, ram_ce, ram_we = 0.
//   - ram_ad, ram_din, r0_rdata, r1_rdata = 0; last_grant = R1, so R0 wins first.
//   - A transaction in flight when reset asserts is dropped; no ack is issued.
//  FSM (all RAM-side outputs registered):
//   - IDLE: if any req, pick a winner and register addr/we/wdata onto ram_* with
//     ram_ce=1; go to ACCESS. Otherwise stay in IDLE with ram_ce=0.
//   - ACCESS: ram_ce=1 during this cycle; the RAM samples at its end.
//     Next cycle ram_ce=0 and ram_we=0; go to READ.
//   - READ: ram_dout is valid. For a read, capture it into rX_rdata at the end
//     of the cycle. Go to DONE with rX_ack registered high.
//   - DONE: rX_ack=1 for exactly this cycle; reqs are ignored. Go to IDLE.
//  Latency and handshake:
//   - req first sampled high at the end of cycle 0 -> ack high in cycle 3.
//     Same for reads and writes.
//   - Requester deasserts req in cycle 4 or later. If req is still high in
//     cycle 4, IDLE treats it as a new access.
//   - Peak throughput is 1 access per 4 clocks.
//   - Write ack: rX_rdata is unchanged.
//  Arbitration:
//   - Evaluated only in IDLE.
//   - R0_PRIO=1: R0 wins whenever r0_req=1.
//   - R0_PRIO=0: if both request, the one not in last_grant wins.
//     last_grant updates on every grant.
//   - The loser's req is simply held; it is never lost or acked early.
//  Boundaries:
//   - Address 0x1FF and 0x000 carry no special handling; addresses do not wrap
//     or increment inside the block.
//   - A req dropped before its ack (protocol violation): the access still
//     completes and acks once.
//   - Simultaneous r0/r1 requests are resolved in IDLE. Only one ram_ce cycle
//     per grant.
// TESTING
//  1. Reset: rst_n=0 mid-ACCESS -> state IDLE, all outputs 0, no ack after release.
//  2. R0 write 0x1FF<=0xA5, then R0 read 0x1FF -> ram_ce high 1 cycle each;
//     r0_ack in cycle 3 of each; r0_rdata=0xA5.
//  3. R1 write 0x000<=0x3C, then read -> r1_rdata=0x3C; r0_rdata unchanged.
//  4. R0_PRIO=0, both req held high continuously -> grants alternate R0,R1,R0,R1;
//     acks every 4 cycles.
//  5. R0_PRIO=1, both req held high -> R0 granted every time; r1_ack never.
//     Drop r0_req -> R1 served next.
//  6. Write ack check: r1 read 0x010 returns 0x77; r1 then writes 0x010 ->
//     r1_rdata stays 0x77 at the write ack.

Source files
------------

// File: rtl/dpb_port_arbiter.sv
// dpb_port_arbiter
//   Shares port A of a 512x8 Gowin DPB block RAM between two requesters:
//   R0 (Z80 bus side) and R1 (ESP/SPI side). Port B of the RAM is left alone.
//   One RAM access runs at a time through a four-state sequencer
//   (IDLE -> ACCESS -> READ -> DONE). Every access, read or write, acks three
//   cycles after its request is first sampled. A new grant is possible at
//   most once every four clocks.
//
// Parameters
//   ADDR_W   RAM address width (9 -> 512 entries)
//   DATA_W   RAM data width
//   R0_PRIO  1: R0 has strict priority; 0: round-robin between R0 and R1
//
// Ports
//   clk, rst_n                 rising-edge clock, asynchronous active-low reset
//   rX_req/we/addr/wdata       requester X access; held stable until rX_ack
//   rX_ack                     one-cycle completion pulse for requester X
//   rX_rdata                   last read data for X; updates only on read acks
//   busy                       high whenever the sequencer is not idle
//   ram_ce/oce/reset/we/ad/din to DPB cea/ocea/reseta/wrea/ada/dina
//   ram_dout                   from DPB douta, valid one cycle after the ce edge

module dpb_port_arbiter #(
  parameter int ADDR_W  = 9,
  parameter int DATA_W  = 8,
  parameter int R0_PRIO = 0
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              r0_req,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_ack,
  output logic [DATA_W-1:0] r0_rdata,

  input  logic              r1_req,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_ack,
  output logic [DATA_W-1:0] r1_rdata,

  output logic              busy,

  output logic              ram_ce,
  output logic              ram_oce,
  output logic              ram_reset,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_ad,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    READ   = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t            state, state_nx;

  // grant / last_grant: 0 = R0, 1 = R1. last_grant resets to R1 so that R0
  // wins the very first contested arbitration.
  logic              grant, grant_nx;
  logic              last_grant, last_grant_nx;

  // ram_we is cleared after the ACCESS cycle, so the direction of the
  // current operation is kept separately for the READ-state decision.
  logic              op_we, op_we_nx;

  logic              ram_ce_nx, ram_we_nx;
  logic [ADDR_W-1:0] ram_ad_nx;
  logic [DATA_W-1:0] ram_din_nx;
  logic              r0_ack_nx, r1_ack_nx;
  logic [DATA_W-1:0] r0_rdata_nx, r1_rdata_nx;

  logic              pick_r1;

  // Bypass read mode with the RAM's own reset unused.
  assign ram_oce   = 1'b1;
  assign ram_reset = 1'b0;
  assign busy      = (state != IDLE);

  // Winner selection, only consumed in IDLE. With priority, R1 wins only
  // when R0 is quiet; otherwise a contested request goes to whoever did
  // not get the previous grant.
  always_comb begin
    pick_r1 = 1'b0;
    if (R0_PRIO != 0) begin
      pick_r1 = ~r0_req;
    end else if (r0_req && r1_req) begin
      pick_r1 = ~last_grant;
    end else begin
      pick_r1 = ~r0_req;
    end
  end

  // Next-state and next-output logic. Every RAM-side and requester-side
  // output is registered from these values.
  always_comb begin
    state_nx      = state;
    grant_nx      = grant;
    last_grant_nx = last_grant;
    op_we_nx      = op_we;
    ram_ce_nx     = 1'b0;
    ram_we_nx     = 1'b0;
    ram_ad_nx     = ram_ad;
    ram_din_nx    = ram_din;
    r0_ack_nx     = 1'b0;
    r1_ack_nx     = 1'b0;
    r0_rdata_nx   = r0_rdata;
    r1_rdata_nx   = r1_rdata;

    unique case (state)
      IDLE: begin
        if (r0_req || r1_req) begin
          grant_nx      = pick_r1;
          last_grant_nx = pick_r1;
          op_we_nx      = pick_r1 ? r1_we    : r0_we;
          ram_ce_nx     = 1'b1;
          ram_we_nx     = pick_r1 ? r1_we    : r0_we;
          ram_ad_nx     = pick_r1 ? r1_addr  : r0_addr;
          ram_din_nx    = pick_r1 ? r1_wdata : r0_wdata;
          state_nx      = ACCESS;
        end
      end

      // The RAM samples ce/we/ad/din at the end of this cycle; dropping
      // ce afterwards guarantees a single RAM cycle per grant.
      ACCESS: begin
        state_nx = READ;
      end

      // ram_dout now reflects the access; only reads update rX_rdata.
      READ: begin
        if (grant) begin
          r1_ack_nx = 1'b1;
          if (!op_we) r1_rdata_nx = ram_dout;
        end else begin
          r0_ack_nx = 1'b1;
          if (!op_we) r0_rdata_nx = ram_dout;
        end
        state_nx = DONE;
      end

      // Ack cycle; requests are ignored so a held req is not re-granted
      // until the following IDLE cycle.
      DONE: begin
        state_nx = IDLE;
      end

      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // State and output registers. Reset abandons any access in flight,
  // which is why no ack can follow a reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      op_we      <= 1'b0;
      ram_ce     <= 1'b0;
      ram_we     <= 1'b0;
      ram_ad     <= '0;
      ram_din    <= '0;
      r0_ack     <= 1'b0;
      r1_ack     <= 1'b0;
      r0_rdata   <= '0;
      r1_rdata   <= '0;
    end else begin
      state      <= state_nx;
      grant      <= grant_nx;
      last_grant <= last_grant_nx;
      op_we      <= op_we_nx;
      ram_ce     <= ram_ce_nx;
      ram_we     <= ram_we_nx;
      ram_ad     <= ram_ad_nx;
      ram_din    <= ram_din_nx;
      r0_ack     <= r0_ack_nx;
      r1_ack     <= r1_ack_nx;
      r0_rdata   <= r0_rdata_nx;
      r1_rdata   <= r1_rdata_nx;
    end
  end

endmodule

// File: tb/tb_dpb_port_arbiter.sv
// tb_dpb_port_arbiter
//   Directed bench for dpb_port_arbiter. Two instances share clock and reset:
//   dut_a is round-robin (R0_PRIO=0), dut_b gives R0 strict priority.
//   Each instance is wired to a small behavioural 512x8 RAM that answers one
//   cycle after a ce edge and shows written data on dout during writes.

module tb_dpb_port_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;

  logic       a_r0_req, a_r0_we, a_r0_ack, a_r1_req, a_r1_we, a_r1_ack;
  logic [8:0] a_r0_addr, a_r1_addr, a_ram_ad;
  logic [7:0] a_r0_wdata, a_r1_wdata, a_r0_rdata, a_r1_rdata;
  logic       a_busy, a_ram_ce, a_ram_oce, a_ram_reset, a_ram_we;
  logic [7:0] a_ram_din, a_ram_dout;
  logic [7:0] a_mem [512];

  logic       b_r0_req, b_r0_we, b_r0_ack, b_r1_req, b_r1_we, b_r1_ack;
  logic [8:0] b_r0_addr, b_r1_addr, b_ram_ad;
  logic [7:0] b_r0_wdata, b_r1_wdata, b_r0_rdata, b_r1_rdata;
  logic       b_busy, b_ram_ce, b_ram_oce, b_ram_reset, b_ram_we;
  logic [7:0] b_ram_din, b_ram_dout;
  logic [7:0] b_mem [512];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dpb_port_arbiter #(.ADDR_W(9), .DATA_W(8), .R0_PRIO(0)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .r0_req(a_r0_req), .r0_we(a_r0_we), .r0_addr(a_r0_addr), .r0_wdata(a_r0_wdata),
    .r0_ack(a_r0_ack), .r0_rdata(a_r0_rdata),
    .r1_req(a_r1_req), .r1_we(a_r1_we), .r1_addr(a_r1_addr), .r1_wdata(a_r1_wdata),
    .r1_ack(a_r1_ack), .r1_rdata(a_r1_rdata),
    .busy(a_busy), .ram_ce(a_ram_ce), .ram_oce(a_ram_oce), .ram_reset(a_ram_reset),
    .ram_we(a_ram_we), .ram_ad(a_ram_ad), .ram_din(a_ram_din), .ram_dout(a_ram_dout)
  );

  dpb_port_arbiter #(.ADDR_W(9), .DATA_W(8), .R0_PRIO(1)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .r0_req(b_r0_req), .r0_we(b_r0_we), .r0_addr(b_r0_addr), .r0_wdata(b_r0_wdata),
    .r0_ack(b_r0_ack), .r0_rdata(b_r0_rdata),
    .r1_req(b_r1_req), .r1_we(b_r1_we), .r1_addr(b_r1_addr), .r1_wdata(b_r1_wdata),
    .r1_ack(b_r1_ack), .r1_rdata(b_r1_rdata),
    .busy(b_busy), .ram_ce(b_ram_ce), .ram_oce(b_ram_oce), .ram_reset(b_ram_reset),
    .ram_we(b_ram_we), .ram_ad(b_ram_ad), .ram_din(b_ram_din), .ram_dout(b_ram_dout)
  );

  // RAM models: write-through dout so that a write ack which wrongly
  // latches dout would expose the new data instead of the old read value.
  always @(posedge clk) begin
    if (a_ram_ce) begin
      if (a_ram_we) begin
        a_mem[a_ram_ad] <= a_ram_din;
        a_ram_dout      <= a_ram_din;
      end else begin
        a_ram_dout <= a_mem[a_ram_ad];
      end
    end
  end

  always @(posedge clk) begin
    if (b_ram_ce) begin
      if (b_ram_we) begin
        b_mem[b_ram_ad] <= b_ram_din;
        b_ram_dout      <= b_ram_din;
      end else begin
        b_ram_dout <= b_mem[b_ram_ad];
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One isolated access on dut_a by requester rq. Called just after a rising
  // edge with dut_a idle; cycle 0 is the cycle in which req first goes high.
  // Returns the requester's rdata as seen in its ack cycle.
  task automatic applyStimulus(input bit rq, input bit we, input logic [8:0] addr,
                               input logic [7:0] wd, input string name,
                               output logic [7:0] ack_rdata);
    int         ack_cyc = -1;
    int         ack_cnt = 0;
    int         ce_cnt = 0;
    int         other_cnt = 0;
    logic [8:0] ce_ad = '0;
    logic       ce_we = 1'b0;
    logic [7:0] ce_din = '0;
    ack_rdata = '0;
    if (rq == 1'b0) begin
      a_r0_we = we; a_r0_addr = addr; a_r0_wdata = wd; a_r0_req = 1'b1;
    end else begin
      a_r1_we = we; a_r1_addr = addr; a_r1_wdata = wd; a_r1_req = 1'b1;
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (a_ram_ce) begin
        ce_cnt++; ce_ad = a_ram_ad; ce_we = a_ram_we; ce_din = a_ram_din;
      end
      if ((rq == 1'b0) ? a_r0_ack : a_r1_ack) begin
        ack_cnt++; ack_cyc = c;
        ack_rdata = (rq == 1'b0) ? a_r0_rdata : a_r1_rdata;
      end
      if ((rq == 1'b0) ? a_r1_ack : a_r0_ack) other_cnt++;
      if (c == 3) begin
        @(posedge clk); #1;
        a_r0_req = 1'b0; a_r1_req = 1'b0;
      end
    end
    @(posedge clk); #1;
    checkOutput({name, " ack cycle"}, 32'(ack_cyc), 32'd3);
    checkOutput({name, " ack count"}, 32'(ack_cnt), 32'd1);
    checkOutput({name, " ce cycles"}, 32'(ce_cnt), 32'd1);
    checkOutput({name, " ram addr"}, 32'(ce_ad), 32'(addr));
    checkOutput({name, " ram we"}, 32'(ce_we), 32'(we));
    if (we) checkOutput({name, " ram din"}, 32'(ce_din), 32'(wd));
    checkOutput({name, " other ack"}, 32'(other_cnt), 32'd0);
  endtask

  initial begin
    logic [7:0] rd;
    logic [1:0] exp_ack;
    int         ce_total;
    int         bad_ack;

    for (int i = 0; i < 512; i++) begin
      a_mem[i] = 8'h00;
      b_mem[i] = 8'h00;
    end
    a_ram_dout = '0; b_ram_dout = '0;
    a_r0_req = 0; a_r0_we = 0; a_r0_addr = '0; a_r0_wdata = '0;
    a_r1_req = 0; a_r1_we = 0; a_r1_addr = '0; a_r1_wdata = '0;
    b_r0_req = 0; b_r0_we = 0; b_r0_addr = '0; b_r0_wdata = '0;
    b_r1_req = 0; b_r1_we = 0; b_r1_addr = '0; b_r1_wdata = '0;

    // Power-on reset: a real falling edge so the async reset fires.
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    checkOutput("reset a flags", 32'({a_busy, a_ram_ce, a_ram_we, a_r0_ack, a_r1_ack, a_ram_oce, a_ram_reset}), 32'b0000010);
    checkOutput("reset a addr/din", 32'({a_ram_ad, a_ram_din}), 32'd0);
    checkOutput("reset a rdata", 32'({a_r0_rdata, a_r1_rdata}), 32'd0);
    checkOutput("reset b flags", 32'({b_busy, b_ram_ce, b_ram_we, b_r0_ack, b_r1_ack, b_ram_oce, b_ram_reset}), 32'b0000010);
    @(posedge clk); @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset asserted while dut_a is in ACCESS: everything clears, no ack later.
    a_r0_we = 1'b1; a_r0_addr = 9'h055; a_r0_wdata = 8'h99; a_r0_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("t1 in access", 32'({a_busy, a_ram_ce, a_ram_we}), 32'b111);
    #1 a_r0_req = 1'b0; rst_n = 1'b0;
    #1;
    checkOutput("t1 reset flags", 32'({a_busy, a_ram_ce, a_ram_we, a_r0_ack, a_r1_ack}), 32'd0);
    checkOutput("t1 reset addr/din", 32'({a_ram_ad, a_ram_din}), 32'd0);
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    bad_ack = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (a_r0_ack || a_r1_ack || a_busy) bad_ack++;
    end
    checkOutput("t1 no ack after reset", 32'(bad_ack), 32'd0);
    @(posedge clk); #1;

    // R0 write then read at the top address.
    applyStimulus(1'b0, 1'b1, 9'h1FF, 8'hA5, "t2 r0 wr", rd);
    checkOutput("t2 r0 rdata after wr", 32'(a_r0_rdata), 32'h00);
    applyStimulus(1'b0, 1'b0, 9'h1FF, 8'h00, "t2 r0 rd", rd);
    checkOutput("t2 r0 rdata at ack", 32'(rd), 32'hA5);

    // R1 write then read at address zero; R0's rdata is untouched.
    applyStimulus(1'b1, 1'b1, 9'h000, 8'h3C, "t3 r1 wr", rd);
    applyStimulus(1'b1, 1'b0, 9'h000, 8'h00, "t3 r1 rd", rd);
    checkOutput("t3 r1 rdata at ack", 32'(rd), 32'h3C);
    checkOutput("t3 r0 rdata kept", 32'(a_r0_rdata), 32'hA5);

    // Write ack leaves rdata holding the previous read value.
    applyStimulus(1'b1, 1'b1, 9'h010, 8'h77, "t6 r1 wr77", rd);
    applyStimulus(1'b1, 1'b0, 9'h010, 8'h00, "t6 r1 rd", rd);
    checkOutput("t6 r1 read 77", 32'(rd), 32'h77);
    applyStimulus(1'b1, 1'b1, 9'h010, 8'h55, "t6 r1 wr55", rd);
    checkOutput("t6 r1 rdata at wr ack", 32'(rd), 32'h77);
    applyStimulus(1'b1, 1'b0, 9'h010, 8'h00, "t6 r1 rd55", rd);
    checkOutput("t6 r1 read 55", 32'(rd), 32'h55);

    // Protocol violation: R1 req high for cycle 0 only, still acked once.
    a_r1_we = 1'b0; a_r1_addr = 9'h000; a_r1_req = 1'b1;
    bad_ack = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      exp_ack = (c == 3) ? 2'b01 : 2'b00;
      if ({a_r0_ack, a_r1_ack} !== exp_ack) bad_ack++;
      if (c == 0) begin
        @(posedge clk); #1 a_r1_req = 1'b0;
      end
    end
    checkOutput("short req acks", 32'(bad_ack), 32'd0);
    checkOutput("short req rdata", 32'(a_r1_rdata), 32'h3C);
    @(posedge clk); #1;

    // Round-robin with both requests held: R0, R1, R0, R1 every 4 cycles.
    a_r0_we = 1'b0; a_r0_addr = 9'h1FF; a_r0_req = 1'b1;
    a_r1_we = 1'b0; a_r1_addr = 9'h000; a_r1_req = 1'b1;
    ce_total = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (a_ram_ce) ce_total++;
      exp_ack = (c == 3 || c == 11) ? 2'b10 : (c == 7 || c == 15) ? 2'b01 : 2'b00;
      checkOutput($sformatf("t4 acks c%0d", c), 32'({a_r0_ack, a_r1_ack}), 32'(exp_ack));
      if (c == 15) begin
        @(posedge clk); #1 a_r0_req = 1'b0; a_r1_req = 1'b0;
      end
    end
    checkOutput("t4 ce total", 32'(ce_total), 32'd4);
    checkOutput("t4 rdata", 32'({a_r0_rdata, a_r1_rdata}), 32'hA53C);
    repeat (3) @(negedge clk);
    checkOutput("t4 idle after", 32'({a_busy, a_r0_ack, a_r1_ack}), 32'd0);
    @(posedge clk); #1;

    // Strict priority: R0 starves R1 until r0_req drops.
    b_r0_we = 1'b0; b_r0_addr = 9'h001; b_r0_req = 1'b1;
    b_r1_we = 1'b0; b_r1_addr = 9'h002; b_r1_req = 1'b1;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      exp_ack = (c == 3 || c == 7 || c == 11) ? 2'b10 : (c == 15) ? 2'b01 : 2'b00;
      checkOutput($sformatf("t5 acks c%0d", c), 32'({b_r0_ack, b_r1_ack}), 32'(exp_ack));
      if (c == 11) begin
        @(posedge clk); #1 b_r0_req = 1'b0;
      end
      if (c == 15) begin
        @(posedge clk); #1 b_r1_req = 1'b0;
      end
    end
    repeat (3) @(negedge clk);
    checkOutput("t5 idle after", 32'({b_busy, b_r0_ack, b_r1_ack}), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
